// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
//   Hamming(7,4) single-error-correcting decoder. It takes one 7-bit codeword,
//   computes the syndrome, flips the indicated bit and returns the four data
//   bits. It also keeps a saturating count of the words it has corrected.
//   Every nonzero syndrome is treated as a single-bit error. Double errors are
//   therefore miscorrected, and this is intentional.
//
// Ports
//   clk        in   1      system clock, all state changes on the rising edge
//   reset      in   1      synchronous, active-high reset
//   de_in      in   7      received codeword {p0,p1,d3,p2,d2,d1,d0} (bit6..bit0)
//   in_valid   in   1      de_in is valid
//   in_ready   out  1      decoder can accept a word (high only in IDLE)
//   de_out     out  4      corrected data {d3,d2,d1,d0}
//   syndrome   out  3      syndrome {s2,s1,s0} of the word in de_out
//   err_flag   out  1      syndrome nonzero, one bit was corrected
//   out_valid  out  1      de_out/syndrome/err_flag valid
//   out_ready  in   1      downstream accepts the result
//   err_count  out  CNT_W  saturating count of words with a nonzero syndrome
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The input side is ready only in IDLE. The output side holds
//   out_valid and all result fields stable until out_ready is seen.
//   de_in only has to be valid during the cycle in which it is accepted.
// -----------------------------------------------------------------------------
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       de_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       de_out,
  output logic [2:0]       syndrome,
  output logic             err_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYND = 2'd1;
  localparam logic [1:0] ST_CORR = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [6:0]       word_q,      word_d;
  logic [2:0]       syn_q,       syn_d;
  logic [3:0]       de_out_q,    de_out_d;
  logic [2:0]       syndrome_q,  syndrome_d;
  logic             err_flag_q,  err_flag_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [2:0] syn_calc;
  logic [6:0] flip_mask;
  logic [6:0] corrected;

  // The parity checks over the latched word. A nonzero result gives the
  // position of the faulty bit, so a single flipped bit yields a unique value.
  assign syn_calc = {word_q[3] ^ word_q[2] ^ word_q[1] ^ word_q[0],
                     word_q[5] ^ word_q[4] ^ word_q[1] ^ word_q[0],
                     word_q[6] ^ word_q[4] ^ word_q[2] ^ word_q[0]};

  always_comb begin
    flip_mask = 7'b000_0000;
    case (syn_q)
      3'd1:    flip_mask = 7'b100_0000;
      3'd2:    flip_mask = 7'b010_0000;
      3'd3:    flip_mask = 7'b001_0000;
      3'd4:    flip_mask = 7'b000_1000;
      3'd5:    flip_mask = 7'b000_0100;
      3'd6:    flip_mask = 7'b000_0010;
      3'd7:    flip_mask = 7'b000_0001;
      default: flip_mask = 7'b000_0000;
    endcase
  end

  assign corrected = word_q ^ flip_mask;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    syn_d       = syn_q;
    de_out_d    = de_out_q;
    syndrome_d  = syndrome_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = de_in;
          state_d = ST_SYND;
        end
      end
      ST_SYND: begin
        syn_d   = syn_calc;
        state_d = ST_CORR;
      end
      ST_CORR: begin
        // The visible syndrome is updated together with de_out. This keeps
        // the two fields describing the same word.
        de_out_d   = {corrected[4], corrected[2], corrected[1], corrected[0]};
        syndrome_d = syn_q;
        err_flag_d = |syn_q;
        if ((|syn_q) && (err_count_q != {CNT_W{1'b1}})) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= 7'd0;
      syn_q       <= 3'd0;
      de_out_q    <= 4'd0;
      syndrome_q  <= 3'd0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      syn_q       <= syn_d;
      de_out_q    <= de_out_d;
      syndrome_q  <= syndrome_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign de_out    = de_out_q;
  assign syndrome  = syndrome_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder
//   This bench drives two decoders (CNT_W=8 and CNT_W=2) with the same inputs.
//   A negedge model decodes every accepted word by searching for the nearest
//   codeword and tracks the expected handshake timing. The directed tasks
//   check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] de_in = 7'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, err_flag_a;
  logic [3:0] de_out_a;
  logic [2:0] syndrome_a;
  logic [7:0] err_count_a;

  logic       in_ready_b, out_valid_b, err_flag_b;
  logic [3:0] de_out_b;
  logic [2:0] syndrome_b;
  logic [1:0] err_count_b;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .de_in(de_in), .in_valid(in_valid),
    .in_ready(in_ready_a), .de_out(de_out_a), .syndrome(syndrome_a),
    .err_flag(err_flag_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .err_count(err_count_a)
  );

  hamming_decoder #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .de_in(de_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .de_out(de_out_b), .syndrome(syndrome_b),
    .err_flag(err_flag_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .err_count(err_count_b)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
            d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
  endfunction

  // The result is {flag, syndrome, data}. The word decodes to the unique
  // codeword within distance 1. The syndrome names the position that differs
  // (bit6 -> 1 ... bit0 -> 7).
  function automatic logic [7:0] model_decode(input logic [6:0] r);
    logic [6:0] diff;
    logic [3:0] dv;
    logic [3:0] data;
    logic [2:0] syn;
    data = 4'd0;
    syn  = 3'd0;
    for (int v = 0; v < 16; v++) begin
      dv   = 4'(v);
      diff = encode(dv) ^ r;
      if ($countones(diff) <= 1) begin
        data = dv;
        for (int p = 0; p < 7; p++) begin
          if (diff[p]) syn = 3'(7 - p);
        end
      end
    end
    return {(syn != 3'd0), syn, data};
  endfunction

  logic       pending = 1'b0;
  logic [7:0] item = 8'd0;
  logic [3:0] last_de = 4'd0;
  logic [2:0] last_syn = 3'd0;
  logic       last_flag = 1'b0;
  int         cnt8 = 0;
  int         cnt2 = 0;
  int         acc_n = 0;
  int         n = 0;
  bit         started = 1'b0;

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic exp_ov;
    if (started) begin
      exp_ov = pending && ((n - acc_n) >= 3);
      check("in_ready_a",  in_ready_a,  !pending);
      check("in_ready_b",  in_ready_b,  !pending);
      check("out_valid_a", out_valid_a, exp_ov);
      check("out_valid_b", out_valid_b, exp_ov);
      check("de_out_a",    de_out_a,    last_de);
      check("de_out_b",    de_out_b,    last_de);
      check("syndrome_a",  syndrome_a,  last_syn);
      check("syndrome_b",  syndrome_b,  last_syn);
      check("err_flag_a",  err_flag_a,  last_flag);
      check("err_flag_b",  err_flag_b,  last_flag);
      check("err_count_a", err_count_a, cnt8);
      check("err_count_b", err_count_b, cnt2);
    end
    if (reset) begin
      started   = 1'b1;
      pending   = 1'b0;
      last_de   = 4'd0;
      last_syn  = 3'd0;
      last_flag = 1'b0;
      cnt8      = 0;
      cnt2      = 0;
    end else if (started) begin
      if (!pending) begin
        if (in_valid) begin
          pending = 1'b1;
          acc_n   = n;
          item    = model_decode(de_in);
        end
      end else if ((n - acc_n) == 2) begin
        last_de   = item[3:0];
        last_syn  = item[6:4];
        last_flag = item[7];
        if (item[7]) begin
          cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
          cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
        end
      end else if (((n - acc_n) >= 3) && out_ready) begin
        pending = 1'b0;
      end
    end
    n++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [6:0] w, input logic [3:0] ed,
                      input logic [2:0] es, input logic ef, input int stall);
    int k;
    check("idle_before_send", in_ready_a, 1'b1);
    de_in = w; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; de_in = 7'h2a;
    k = 1;
    while (out_valid_a !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 3);
    check("lit_de_out", de_out_a, ed);
    check("lit_syndrome", syndrome_a, es);
    check("lit_err_flag", err_flag_a, ef);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; de_in = ~w;
      check("stall_in_ready", in_ready_a, 1'b0);
      check("stall_out_valid", out_valid_a, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready_a, 1'b1);
    check("post_hs_out_valid", out_valid_a, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [2:0] syn_tab [7] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  logic [1:0] sat_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    logic [6:0] w;
    logic [3:0] dv;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_de_out", de_out_a, 4'd0);
    check("rst_err_count", err_count_a, 8'd0);

    // Clean codeword, then a single error in bit 4.
    send(7'b0110011, 4'b1011, 3'b000, 1'b0, 0);
    check("t1_err_count", err_count_a, 8'd0);
    send(7'b0100011, 4'b1011, 3'b011, 1'b1, 0);
    check("t2_err_count", err_count_a, 8'd1);

    // All seven single-bit flips of the all-ones codeword.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      w = 7'h7f;
      w[i] = 1'b0;
      send(w, 4'hf, syn_tab[i], 1'b1, 0);
    end
    check("t2_err_count7", err_count_a, 8'd7);
    check("t2_err_count_sat", err_count_b, 2'd3);

    // Double error: miscorrected to the codeword nearest the received word.
    send(7'b0110000, 4'b1000, 3'b001, 1'b1, 0);

    // Backpressure: hold OUT for 10 cycles while in_valid is driven.
    send(7'b0110011, 4'b1011, 3'b000, 1'b0, 10);

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w = 7'h7f;
      w[i] = 1'b0;
      send(w, 4'hf, syn_tab[i], 1'b1, 0);
      check("t4_sat_count", err_count_b, sat_tab[i]);
    end

    // Reset while in SYND.
    de_in = 7'b0100011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_synd_in_ready", in_ready_a, 1'b1);
    check("rst_synd_out_valid", out_valid_a, 1'b0);
    check("rst_synd_err_count", err_count_a, 8'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_synd_no_output", out_valid_a, 1'b0);
    end

    // Reset while in OUT.
    send(7'b0100011, 4'b1011, 3'b011, 1'b1, 0);
    de_in = 7'b0100011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_out_reached", out_valid_a, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_out_in_ready", in_ready_a, 1'b1);
    check("rst_out_out_valid", out_valid_a, 1'b0);
    check("rst_out_err_count", err_count_a, 8'd0);
    send(7'b0000000, 4'b0000, 3'b000, 1'b0, 0);

    // Encoder loopback over all data values.
    for (int v = 0; v < 16; v++) begin
      dv = 4'(v);
      send(encode(dv), dv, 3'b000, 1'b0, 0);
    end
    check("loop_err_count", err_count_a, 8'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
